// File: rtl/bus_scatter_pkg.sv
// Shared encodings and helpers for the QSPI return-path router (bus_scatter).
package bus_scatter_pkg;

  typedef enum logic [1:0] {
    OWN_I = 2'd0,
    OWN_D = 2'd1,
    OWN_U = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    SZ_B  = 2'd0,
    SZ_HW = 2'd1,
    SZ_W  = 2'd2
  } size_e;

  localparam int unsigned TAG_W = 6;

  typedef struct packed {
    owner_e     owner;
    size_e      size;
    logic [1:0] adr_lo;
  } tag_t;

  // Lane-select and zero-extend a raw QSPI word; sign extension is left to the requester.
  function automatic logic [31:0] align_rdata(input size_e sz, input logic [1:0] lo,
                                               input logic [31:0] raw);
    logic [31:0] r;
    r = '0;
    case (sz)
      SZ_W:    r = raw;
      SZ_HW:   r = {16'h0000, (lo[1] ? raw[31:16] : raw[15:0])};
      default: begin
        case (lo)
          2'd0:    r = {24'h000000, raw[7:0]};
          2'd1:    r = {24'h000000, raw[15:8]};
          2'd2:    r = {24'h000000, raw[23:16]};
          default: r = {24'h000000, raw[31:24]};
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_scatter_tag_fifo.sv
// In-order tag FIFO; a push while full is accepted only when a pop happens in the same cycle.
module tag_fifo #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned WIDTH      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0] rptr_q, rptr_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                do_push, do_pop;

  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[DEPTH_LOG2-1:0]] = wdata;
      wptr_d = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    // Extra MSB distinguishes full from empty when the index bits match.
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[DEPTH_LOG2] != rptr_d[DEPTH_LOG2]) &&
              (wptr_d[DEPTH_LOG2-1:0] == rptr_d[DEPTH_LOG2-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      mem_q   <= '{default: '0};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      mem_q   <= mem_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign rdata = mem_q[rptr_q[DEPTH_LOG2-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/bus_scatter.sv
// Routes QSPI read responses and write completions back to the i/d/u masters.
// Optional BUS_SCATTER_ERR_EN adds a sticky resp_err output for protocol violations.
module bus_scatter
  import bus_scatter_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read_req,
  input  logic        d_read_req,
  input  logic        u_read_req,
  input  logic        read_w,
  input  logic        read_hw,
  input  logic [1:0]  read_adr_lo,
  input  logic        d_write_req,
  input  logic        u_write_req,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  input  logic        wr_done,
  output logic        i_read_valid,
  output logic        d_read_valid,
  output logic        u_read_valid,
  output logic [31:0] i_read_data,
  output logic [31:0] d_read_data,
  output logic [31:0] u_read_data,
  output logic        d_write_done,
  output logic        u_write_done,
  output logic        tag_full,
  output logic        wr_busy
`ifdef BUS_SCATTER_ERR_EN
  ,
  output logic        resp_err
`endif
);

  logic             read_req;
  tag_t             push_tag;
  tag_t             head_tag;
  logic [TAG_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic             pop_ok;
  logic [31:0]      aligned;
  logic             any_wreq;
  logic             done_fire;
  owner_e           wreq_owner;

  logic [31:0] i_data_q, i_data_d;
  logic [31:0] d_data_q, d_data_d;
  logic [31:0] u_data_q, u_data_d;
  logic        i_valid_q, i_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        u_valid_q, u_valid_d;
  logic        d_done_q, d_done_d;
  logic        u_done_q, u_done_d;
  logic        wr_busy_q, wr_busy_d;
  owner_e      wr_owner_q, wr_owner_d;

  assign read_req = i_read_req || d_read_req || u_read_req;

  always_comb begin
    push_tag.owner  = u_read_req ? OWN_U : (i_read_req ? OWN_I : OWN_D);
    push_tag.size   = read_w ? SZ_W : (read_hw ? SZ_HW : SZ_B);
    push_tag.adr_lo = read_adr_lo;
  end

  tag_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (TAG_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (read_req),
    .pop   (rd_valid),
    .wdata (push_tag),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_tag = tag_t'(fifo_rdata);
  assign pop_ok   = rd_valid && !fifo_empty;
  assign aligned  = align_rdata(head_tag.size, head_tag.adr_lo, rd_data);

  always_comb begin
    i_data_d  = i_data_q;
    d_data_d  = d_data_q;
    u_data_d  = u_data_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    u_valid_d = 1'b0;
    if (pop_ok) begin
      case (head_tag.owner)
        OWN_I: begin
          i_data_d  = aligned;
          i_valid_d = 1'b1;
        end
        OWN_D: begin
          d_data_d  = aligned;
          d_valid_d = 1'b1;
        end
        OWN_U: begin
          u_data_d  = aligned;
          u_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign any_wreq   = d_write_req || u_write_req;
  assign wreq_owner = u_write_req ? OWN_U : OWN_D;
  assign done_fire  = wr_done && wr_busy_q;

  // A completion frees the slot in the same cycle, so a coincident request is taken.
  always_comb begin
    wr_busy_d  = wr_busy_q;
    wr_owner_d = wr_owner_q;
    d_done_d   = 1'b0;
    u_done_d   = 1'b0;
    if (done_fire) begin
      d_done_d  = (wr_owner_q == OWN_D);
      u_done_d  = (wr_owner_q == OWN_U);
      wr_busy_d = any_wreq;
      if (any_wreq) begin
        wr_owner_d = wreq_owner;
      end
    end else if (!wr_busy_q && any_wreq) begin
      wr_busy_d  = 1'b1;
      wr_owner_d = wreq_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_data_q   <= '0;
      d_data_q   <= '0;
      u_data_q   <= '0;
      i_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      u_valid_q  <= 1'b0;
      d_done_q   <= 1'b0;
      u_done_q   <= 1'b0;
      wr_busy_q  <= 1'b0;
      wr_owner_q <= OWN_D;
    end else begin
      i_data_q   <= i_data_d;
      d_data_q   <= d_data_d;
      u_data_q   <= u_data_d;
      i_valid_q  <= i_valid_d;
      d_valid_q  <= d_valid_d;
      u_valid_q  <= u_valid_d;
      d_done_q   <= d_done_d;
      u_done_q   <= u_done_d;
      wr_busy_q  <= wr_busy_d;
      wr_owner_q <= wr_owner_d;
    end
  end

`ifdef BUS_SCATTER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (read_req && fifo_full && !rd_valid)
          | (rd_valid && fifo_empty)
          | (wr_done && !wr_busy_q)
          | (any_wreq && wr_busy_q && !wr_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`endif

  assign i_read_valid = i_valid_q;
  assign d_read_valid = d_valid_q;
  assign u_read_valid = u_valid_q;
  assign i_read_data  = i_data_q;
  assign d_read_data  = d_data_q;
  assign u_read_data  = u_data_q;
  assign d_write_done = d_done_q;
  assign u_write_done = u_done_q;
  assign tag_full     = fifo_full;
  assign wr_busy      = wr_busy_q;

endmodule

// File: tb/tb_bus_scatter.sv
// Bench for bus_scatter: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_bus_scatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read_req, d_read_req, u_read_req;
  logic        read_w, read_hw;
  logic [1:0]  read_adr_lo;
  logic        d_write_req, u_write_req;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wr_done;
  logic        i_read_valid, d_read_valid, u_read_valid;
  logic [31:0] i_read_data, d_read_data, u_read_data;
  logic        d_write_done, u_write_done;
  logic        tag_full, wr_busy;
`ifdef BUS_SCATTER_ERR_EN
  logic        resp_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_scatter #(.DEPTH_LOG2(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read_req   (i_read_req),
    .d_read_req   (d_read_req),
    .u_read_req   (u_read_req),
    .read_w       (read_w),
    .read_hw      (read_hw),
    .read_adr_lo  (read_adr_lo),
    .d_write_req  (d_write_req),
    .u_write_req  (u_write_req),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wr_done      (wr_done),
    .i_read_valid (i_read_valid),
    .d_read_valid (d_read_valid),
    .u_read_valid (u_read_valid),
    .i_read_data  (i_read_data),
    .d_read_data  (d_read_data),
    .u_read_data  (u_read_data),
    .d_write_done (d_write_done),
    .u_write_done (u_write_done),
    .tag_full     (tag_full),
    .wr_busy      (wr_busy)
`ifdef BUS_SCATTER_ERR_EN
    ,
    .resp_err     (resp_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index 0=i 1=d 2=u, size in bytes.
  typedef struct {
    int unsigned own;
    int unsigned nbytes;
    int unsigned lo;
  } mtag_t;

  mtag_t       mq[$];
  logic [31:0] m_data [3];
  bit          m_valid [3];
  bit          m_ddone, m_udone, m_busy, m_err;
  int unsigned m_wown;

  function automatic logic [31:0] model_align(input mtag_t t, input logic [31:0] raw);
    int unsigned sh;
    if (t.nbytes == 4) return raw;
    sh = (t.nbytes == 2) ? (t.lo / 2) * 16 : t.lo * 8;
    return (t.nbytes == 2) ? ((raw >> sh) & 32'h0000_FFFF) : ((raw >> sh) & 32'h0000_00FF);
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mq.delete();
      for (int k = 0; k < 3; k++) begin
        m_data[k]  = '0;
        m_valid[k] = 1'b0;
      end
      m_ddone = 0; m_udone = 0; m_busy = 0; m_err = 0; m_wown = 1;
    end else begin
      bit    was_full, was_empty, popped, rq, wq;
      mtag_t t;
      was_full  = (mq.size() == 4);
      was_empty = (mq.size() == 0);
      popped    = 0;
      rq        = i_read_req | d_read_req | u_read_req;
      wq        = d_write_req | u_write_req;
      for (int k = 0; k < 3; k++) m_valid[k] = 1'b0;
      m_ddone = 0;
      m_udone = 0;
      if (rd_valid && !was_empty) begin
        t = mq.pop_front();
        m_data[t.own]  = model_align(t, rd_data);
        m_valid[t.own] = 1'b1;
        popped = 1;
      end
      if (rq && (!was_full || popped)) begin
        t.own    = u_read_req ? 2 : (i_read_req ? 0 : 1);
        t.nbytes = read_w ? 4 : (read_hw ? 2 : 1);
        t.lo     = read_adr_lo;
        mq.push_back(t);
      end
      if ((rq && was_full && !popped) || (rd_valid && was_empty) ||
          (wr_done && !m_busy) || (wq && m_busy && !wr_done))
        m_err = 1;
      if (wr_done && m_busy) begin
        m_ddone = (m_wown == 1);
        m_udone = (m_wown == 2);
        m_busy  = wq;
        if (wq) m_wown = u_write_req ? 2 : 1;
      end else if (!m_busy && wq) begin
        m_busy = 1;
        m_wown = u_write_req ? 2 : 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("i_read_valid", i_read_valid, m_valid[0]);
      chk("d_read_valid", d_read_valid, m_valid[1]);
      chk("u_read_valid", u_read_valid, m_valid[2]);
      chk("i_read_data", i_read_data, m_data[0]);
      chk("d_read_data", d_read_data, m_data[1]);
      chk("u_read_data", u_read_data, m_data[2]);
      chk("d_write_done", d_write_done, m_ddone);
      chk("u_write_done", u_write_done, m_udone);
      chk("tag_full", tag_full, mq.size() == 4);
      chk("wr_busy", wr_busy, m_busy);
`ifdef BUS_SCATTER_ERR_EN
      chk("resp_err", resp_err, m_err);
`endif
    end
  end

  task automatic idle();
    i_read_req = 0; d_read_req = 0; u_read_req = 0;
    read_w = 0; read_hw = 0; read_adr_lo = 2'd0;
    d_write_req = 0; u_write_req = 0;
    rd_valid = 0; rd_data = '0; wr_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_rd(input int own, input bit w, input bit hw, input logic [1:0] lo);
    idle();
    i_read_req = (own == 0); d_read_req = (own == 1); u_read_req = (own == 2);
    read_w = w; read_hw = hw; read_adr_lo = lo;
    tick();
    idle();
  endtask

  task automatic resp(input logic [31:0] v);
    idle();
    rd_valid = 1; rd_data = v;
    tick();
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    idle();
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("lit_reset_full", tag_full, 0);
    chk("lit_reset_data", i_read_data, 32'h0);

    // single word read to i
    push_rd(0, 1, 0, 2'd0);
    rd_valid = 1; rd_data = 32'hDEADBEEF;
    tick();
    idle();
    chk("lit_single_valid", i_read_valid, 1);
    chk("lit_single_data", i_read_data, 32'hDEADBEEF);
    chk("lit_single_d_untouched", d_read_data, 32'h0);
    tick();
    chk("lit_single_pulse_end", i_read_valid, 0);

    // halfword then byte alignment
    push_rd(1, 0, 1, 2'd2);
    push_rd(1, 0, 0, 2'd3);
    resp(32'h12345678);
    chk("lit_hw_align", d_read_data, 32'h00001234);
    resp(32'h12345678);
    chk("lit_b_align", d_read_data, 32'h00000012);

    // ordering i,d,u,d
    push_rd(0, 1, 0, 2'd0);
    push_rd(1, 1, 0, 2'd0);
    push_rd(2, 1, 0, 2'd0);
    push_rd(1, 1, 0, 2'd0);
    chk("lit_order_full", tag_full, 1);
    resp(32'h11111111);
    chk("lit_order_i", i_read_data, 32'h11111111);
    resp(32'h22222222);
    chk("lit_order_d", d_read_data, 32'h22222222);
    resp(32'h33333333);
    chk("lit_order_u", u_read_data, 32'h33333333);
    resp(32'h44444444);
    chk("lit_order_d2", d_read_valid, 1);
    chk("lit_order_empty", tag_full, 0);

    // priority u over i
    idle();
    u_read_req = 1; i_read_req = 1; read_w = 1;
    tick();
    resp(32'hA5A5A5A5);
    chk("lit_prio_u", u_read_data, 32'hA5A5A5A5);
    chk("lit_prio_i_kept", i_read_data, 32'h11111111);

    // full with coincident pop, then full push alone
    repeat (4) push_rd(0, 1, 0, 2'd0);
    idle();
    d_read_req = 1; read_w = 1; rd_valid = 1; rd_data = 32'h55;
    tick();
    idle();
    chk("lit_fullpop_full", tag_full, 1);
    chk("lit_fullpop_resp", i_read_data, 32'h55);
    push_rd(2, 1, 0, 2'd0);
    chk("lit_fulldrop_full", tag_full, 1);
`ifdef BUS_SCATTER_ERR_EN
    chk("lit_err_sticky", resp_err, 1);
`endif
    repeat (3) resp(32'h66);
    resp(32'h77);
    chk("lit_drop_last_d", d_read_data, 32'h77);
    resp(32'h88);
    chk("lit_empty_no_valid", i_read_valid | d_read_valid | u_read_valid, 0);

    // writes
    idle(); u_write_req = 1; tick(); idle();
    chk("lit_wr_busy", wr_busy, 1);
    wr_done = 1; tick(); idle();
    chk("lit_wr_udone", u_write_done, 1);
    chk("lit_wr_idle", wr_busy, 0);
    u_write_req = 1; tick(); idle();
    wr_done = 1; d_write_req = 1; tick(); idle();
    chk("lit_relatch_udone", u_write_done, 1);
    chk("lit_relatch_busy", wr_busy, 1);
    wr_done = 1; tick(); idle();
    chk("lit_relatch_ddone", d_write_done, 1);

    // reset with pending tags
    push_rd(0, 1, 0, 2'd0);
    push_rd(1, 1, 0, 2'd0);
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    resp(32'hCAFEF00D);
    chk("lit_rst_no_valid", i_read_valid | d_read_valid | u_read_valid, 0);
    chk("lit_rst_i_data", i_read_data, 32'h0);
    chk("lit_rst_busy", wr_busy, 0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      idle();
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
      end
      i_read_req  = ($urandom_range(0, 5) == 0);
      d_read_req  = ($urandom_range(0, 5) == 0);
      u_read_req  = ($urandom_range(0, 7) == 0);
      read_w      = ($urandom_range(0, 2) == 0);
      read_hw     = $urandom_range(0, 1);
      read_adr_lo = 2'($urandom_range(0, 3));
      rd_valid    = ($urandom_range(0, 2) == 0);
      rd_data     = $urandom;
      d_write_req = ($urandom_range(0, 7) == 0);
      u_write_req = ($urandom_range(0, 7) == 0);
      wr_done     = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
